riscv_core_wb_arbiter: RTL and testbench
========================================

// Module: riscv_core_wb_arbiter
// PURPOSE
//  Writeback arbiter between the functional units (ALU, MUL, MEM) and the reorder buffer.
//  Buffers completed results per source and drains at most one per cycle, chosen round-robin.
//  The granted result writes the register file and drives the ROB fill port (rob_fill_val/slot).
//  The ROB fill port has no back-pressure, so this block absorbs all completion-rate mismatch.
// PARAMETERS
//  NUM_SRC     3   number of result sources (index 0=ALU, 1=MUL, 2=MEM)
//  FIFO_DEPTH  2   entries per source FIFO (power of two, >=2)
//  DATA_W      32  result data width
//  SLOT_W      4   ROB slot index width
//  PREG_W      5   destination register index width
// PORTS
//  clk            in   1               clock, all state on posedge
//  reset          in   1               synchronous, active-high
//  src_val        in   NUM_SRC         per-source result valid
//  src_rdy        out  NUM_SRC         per-source FIFO can accept
//  src_slot       in   NUM_SRC*SLOT_W  ROB slot of each result; source i at [i*SLOT_W +: SLOT_W]
//  src_preg       in   NUM_SRC*PREG_W  destination register, packed the same way
//  src_data       in   NUM_SRC*DATA_W  result data, packed the same way
//  wb_val         out  1               a result is written back this cycle
//  wb_src         out  NUM_SRC         one-hot grant, for debug and coverage
//  wb_rf_wen      out  1               register file write enable
//  wb_rf_waddr    out  PREG_W          register file write address
//  wb_rf_wdata    out  DATA_W          register file write data
//  rob_fill_val   out  1               equals wb_val
//  rob_fill_slot  out  SLOT_W          ROB slot being marked complete
// BEHAVIOUR
//  Reset (sync): every FIFO is emptied and rr_ptr=0.
//   - The cycle after the reset edge: wb_val=0, rob_fill_val=0, wb_rf_wen=0, wb_src=0.
//   - src_rdy is forced to 0 while reset is high, and is all-ones on the first cycle after it.
//   - Reset asserted mid-stream discards all buffered results and produces no fill.
//  Enqueue: src_val[i] && src_rdy[i] at a posedge pushes {slot,preg,data} into FIFO i.
//   - src_rdy[i] = !full[i] && !reset. There is no pass-through when full, even if FIFO i drains that cycle.
//   - src_val[i] while !src_rdy[i] is ignored. The source must hold its result.
//  Latency: a result enqueued at edge N appears on wb_* no earlier than the cycle after edge N.
//   - No combinational input-to-output path exists.
//  Arbitration: combinational over the non-empty FIFO heads.
//   - Search order is rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC. The first non-empty source wins.
//   - On a grant to source g, rr_ptr <= (g==NUM_SRC-1) ? 0 : g+1, and FIFO g pops at that edge.
//   - With no grant, rr_ptr holds.
//  Outputs:
//   - wb_val = any FIFO non-empty.
//   - wb_rf_waddr, wb_rf_wdata and rob_fill_slot come from the winner's head.
//   - When wb_val=0, wb_rf_waddr, wb_rf_wdata and rob_fill_slot are driven to 0.
//   - wb_rf_wen = wb_val && (wb_rf_waddr != 0). x0 is never written, but rob_fill_val still fires.
//  Simultaneous events:
//   - Enqueue and pop of the same non-full FIFO in one cycle: occupancy is unchanged, order is preserved.
//   - All sources may enqueue in the same cycle.
//  FIFO pointers: width log2(FIFO_DEPTH)+1. The MSB distinguishes full from empty, and pointers wrap naturally.
//  Fairness: a continuously non-empty source is granted at least once every NUM_SRC cycles.
//  Ordering: per-source order is FIFO. Cross-source order is unconstrained, since the ROB commits in program order.
//  Protocol error: two buffered entries with the same slot.
//   - The bench asserts this never happens. The RTL does not check it.
// STRUCTURE
//  Shared package riscv_core_pkg holds:
//   - the SLOT_W and PREG_W constants, shared with the ROB and the scoreboard
//   - the SRC_ALU, SRC_MUL and SRC_MEM index constants
//   - typedef wb_entry_t = {slot, preg, data}
//  Sub-module riscv_core_wb_fifo (sync FIFO: enq_val/enq_rdy, deq_val/deq_pop, head output).
//   - It is instantiated NUM_SRC times.
//   - The arbiter and rr_ptr sit in the top level.
// TESTING
//  1. Reset, no src_val -> wb_val=0, rob_fill_val=0, src_rdy=3'b111 from the first cycle after reset.
//  2. ALU pushes slot=3, preg=7, data=0xDEAD at edge N
//     -> at N+1: wb_val=1, rob_fill_slot=3, wb_rf_waddr=7, wb_rf_wdata=0xDEAD, wb_src=3'b001.
//  3. All three sources push in one cycle (slots 1, 2, 3), rr_ptr=0
//     -> fills slot 1, 2, 3 on consecutive cycles, wb_src 001, 010, 100.
//  4. MUL pushes slots 4, 5 back-to-back with no drain while ALU is continuously busy
//     -> src_rdy[1]=0 after 2 entries, outputs alternate ALU/MUL, MUL slots exit in order 4, 5.
//  5. preg=0, slot=9 -> rob_fill_val=1, rob_fill_slot=9, wb_rf_wen=0.
//  6. Reset asserted with 2 MEM entries buffered -> no fill after the reset edge, src_rdy=0 during reset.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared core definitions: ROB slot / physical register widths, writeback
// source indices, and the buffered writeback entry layout.
package riscv_core_pkg;

    localparam int unsigned SLOT_W = 4;
    localparam int unsigned PREG_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MUL = 1;
    localparam int unsigned SRC_MEM = 2;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/riscv_core_wb_fifo.sv
// Per-source result FIFO for the writeback arbiter.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_enq_val / o_enq_rdy   push handshake (rdy low while full or in reset)
//   i_enq_data              entry to push
//   o_deq_val               FIFO non-empty
//   i_deq_pop               pop the head this edge (ignored when empty)
//   o_head                  current head entry
module riscv_core_wb_fifo
    import riscv_core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enq_val,
    output logic               o_enq_rdy,
    input  logic [ENTRY_W-1:0] i_enq_data,
    output logic               o_deq_val,
    input  logic               i_deq_pop,
    output logic [ENTRY_W-1:0] o_head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // Readiness depends only on current occupancy: no pass-through when full.
    assign o_enq_rdy = !w_full && !i_reset;
    assign w_push    = i_enq_val && o_enq_rdy;
    assign o_deq_val = !w_empty;
    assign w_pop     = i_deq_pop && !w_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_enq_data;
    end

endmodule

// File: rtl/riscv_core_wb_arbiter.sv
// Writeback arbiter: buffers completed results from each functional unit and
// drains at most one per cycle, round-robin, into the register file and the
// ROB fill port (which has no back-pressure).
// Ports:
//   i_clk, i_reset                          clock, synchronous active-high reset
//   i_src_val / o_src_rdy                   per-source result handshake
//   i_src_slot / i_src_preg / i_src_data    packed per-source payload, source i at [i*W +: W]
//   o_wb_val, o_wb_src                      writeback valid, one-hot grant
//   o_wb_rf_wen/_waddr/_wdata               register file write port (x0 never written)
//   o_rob_fill_val, o_rob_fill_slot         ROB completion marking
module riscv_core_wb_arbiter
    import riscv_core_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_SRC-1:0]        i_src_val,
    output logic [NUM_SRC-1:0]        o_src_rdy,
    input  logic [NUM_SRC*SLOT_W-1:0] i_src_slot,
    input  logic [NUM_SRC*PREG_W-1:0] i_src_preg,
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    output logic                      o_wb_val,
    output logic [NUM_SRC-1:0]        o_wb_src,
    output logic                      o_wb_rf_wen,
    output logic [PREG_W-1:0]         o_wb_rf_waddr,
    output logic [DATA_W-1:0]         o_wb_rf_wdata,
    output logic                      o_rob_fill_val,
    output logic [SLOT_W-1:0]         o_rob_fill_slot
);

    localparam int unsigned RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [RR_W-1:0]    r_rr_ptr;
    logic [NUM_SRC-1:0] w_deq_val;
    logic [NUM_SRC-1:0] w_pop;
    wb_entry_t          w_head [NUM_SRC];
    wb_entry_t          w_win;
    logic               w_found;
    logic [RR_W-1:0]    w_gnt_idx;
    logic [RR_W-1:0]    w_cand;

    // Source index base+off, wrapped modulo NUM_SRC (off < NUM_SRC).
    function automatic logic [RR_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        return RR_W'((s >= NUM_SRC) ? (s - NUM_SRC) : s);
    endfunction

    // One FIFO per source
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_entry_t w_enq_entry;

        assign w_enq_entry.slot = i_src_slot[g*SLOT_W +: SLOT_W];
        assign w_enq_entry.preg = i_src_preg[g*PREG_W +: PREG_W];
        assign w_enq_entry.data = i_src_data[g*DATA_W +: DATA_W];

        riscv_core_wb_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_enq_val  (i_src_val[g]),
            .o_enq_rdy  (o_src_rdy[g]),
            .i_enq_data (w_enq_entry),
            .o_deq_val  (w_deq_val[g]),
            .i_deq_pop  (w_pop[g]),
            .o_head     (w_head[g])
        );
    end

    // Round-robin search starting at r_rr_ptr; first non-empty head wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_pop     = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_cand = wrap_idx(32'(r_rr_ptr), k);
            if (!w_found && w_deq_val[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (w_found) w_pop[w_gnt_idx] = 1'b1;
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_gnt_idx == RR_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + RR_W'(1);
        end
    end

    // Writeback outputs decode only registered FIFO state.
    assign w_win           = w_head[w_gnt_idx];
    assign o_wb_val        = w_found;
    assign o_wb_src        = w_pop;
    assign o_wb_rf_waddr   = w_found ? w_win.preg : '0;
    assign o_wb_rf_wdata   = w_found ? w_win.data : '0;
    assign o_rob_fill_slot = w_found ? w_win.slot : '0;
    assign o_rob_fill_val  = w_found;
    assign o_wb_rf_wen     = w_found && (o_wb_rf_waddr != '0);

endmodule

// File: tb/tb_riscv_core_wb_arbiter.sv
// Bench for riscv_core_wb_arbiter: directed vector table with hand-derived
// expectations, then a random phase; a per-source scoreboard and round-robin
// model check every cycle.
module tb_riscv_core_wb_arbiter;
    import riscv_core_pkg::*;

    localparam int unsigned NS    = 3;
    localparam int unsigned DEPTH = 2;
    localparam int          NTV   = 20;

    logic                 clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic [NS-1:0]        i_src_val = '0;
    logic [NS-1:0]        o_src_rdy;
    logic [NS*SLOT_W-1:0] i_src_slot = '0;
    logic [NS*PREG_W-1:0] i_src_preg = '0;
    logic [NS*DATA_W-1:0] i_src_data = '0;
    logic                 o_wb_val;
    logic [NS-1:0]        o_wb_src;
    logic                 o_wb_rf_wen;
    logic [PREG_W-1:0]    o_wb_rf_waddr;
    logic [DATA_W-1:0]    o_wb_rf_wdata;
    logic                 o_rob_fill_val;
    logic [SLOT_W-1:0]    o_rob_fill_slot;

    riscv_core_wb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_src_val       (i_src_val),
        .o_src_rdy       (o_src_rdy),
        .i_src_slot      (i_src_slot),
        .i_src_preg      (i_src_preg),
        .i_src_data      (i_src_data),
        .o_wb_val        (o_wb_val),
        .o_wb_src        (o_wb_src),
        .o_wb_rf_wen     (o_wb_rf_wen),
        .o_wb_rf_waddr   (o_wb_rf_waddr),
        .o_wb_rf_wdata   (o_wb_rf_wdata),
        .o_rob_fill_val  (o_rob_fill_val),
        .o_rob_fill_slot (o_rob_fill_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NS-1:0] val;
        logic [3:0]    s0, s1, s2;
        logic [4:0]    p0, p1, p2;
        logic [31:0]   d;
        logic [NS-1:0] exp_rdy;
        logic          exp_val;
        logic [NS-1:0] exp_src;
        logic [3:0]    exp_slot;
        logic          exp_wen;
    } vec_t;

    vec_t          tv [NTV];
    wb_entry_t     q [NS][$];
    int            m_rr = 0;
    int            total = 0;
    int            bad = 0;
    logic [NS-1:0] obs_rdy;

    function automatic vec_t mk(logic rst, logic [2:0] val, logic [3:0] s0, s1, s2,
                                logic [4:0] p0, p1, p2, logic [31:0] d, logic [2:0] rdy,
                                logic ev, logic [2:0] es, logic [3:0] eslot, logic ew);
        vec_t v;
        v.rst = rst; v.val = val; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.p0 = p0; v.p1 = p1; v.p2 = p2; v.d = d; v.exp_rdy = rdy;
        v.exp_val = ev; v.exp_src = es; v.exp_slot = eslot; v.exp_wen = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NS; k++) begin
            int idx;
            idx = (m_rr + k) % NS;
            if (q[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit slot_used(input logic [SLOT_W-1:0] s);
        for (int i = 0; i < NS; i++)
            foreach (q[i][j]) if (q[i][j].slot == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        int g;
        g = model_grant();
        chk("wb_val", o_wb_val, g >= 0);
        chk("rob_fill_val", o_rob_fill_val, g >= 0);
        if (g >= 0) begin
            chk("wb_src", o_wb_src, 64'(1) << g);
            chk("fill_slot", o_rob_fill_slot, q[g][0].slot);
            chk("rf_waddr", o_wb_rf_waddr, q[g][0].preg);
            chk("rf_wdata", o_wb_rf_wdata, q[g][0].data);
            chk("rf_wen", o_wb_rf_wen, q[g][0].preg != 0);
        end else begin
            chk("wb_src_idle", o_wb_src, 0);
            chk("fill_slot_idle", o_rob_fill_slot, 0);
            chk("rf_waddr_idle", o_wb_rf_waddr, 0);
            chk("rf_wdata_idle", o_wb_rf_wdata, 0);
            chk("rf_wen_idle", o_wb_rf_wen, 0);
        end
    endtask

    // Entered just after a negedge; drives one cycle, updates the model at the edge.
    task automatic step(input logic rst, input logic [NS-1:0] val, input wb_entry_t [NS-1:0] e);
        logic [NS-1:0] exp_rdy;
        int g;
        i_reset   = rst;
        i_src_val = val;
        for (int i = 0; i < NS; i++) begin
            i_src_slot[i*SLOT_W +: SLOT_W] = e[i].slot;
            i_src_preg[i*PREG_W +: PREG_W] = e[i].preg;
            i_src_data[i*DATA_W +: DATA_W] = e[i].data;
        end
        #1;
        for (int i = 0; i < NS; i++) exp_rdy[i] = !rst && (q[i].size() < DEPTH);
        obs_rdy = o_src_rdy;
        chk("src_rdy", o_src_rdy, exp_rdy);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NS; i++) q[i].delete();
            m_rr = 0;
        end else begin
            g = model_grant();
            if (g >= 0) begin
                void'(q[g].pop_front());
                m_rr = (g == NS - 1) ? 0 : g + 1;
            end
            for (int i = 0; i < NS; i++) begin
                if (val[i] && exp_rdy[i]) begin
                    chk("slot_unique", slot_used(e[i].slot), 0);
                    q[i].push_back(e[i]);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        wb_entry_t [NS-1:0] e;
        logic [NS-1:0]      pend;
        wb_entry_t [NS-1:0] pe;
        logic               rst;
        int                 scnt;

        //          rst val    s0 s1 s2  p0  p1  p2  data          rdy    ev es     slot wen
        tv[0]  = mk(1, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b000, 0, 3'b000, 0,  0);
        tv[1]  = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 0, 3'b000, 0,  0);
        tv[2]  = mk(0, 3'b001, 3, 0, 0,  7,  0,  0,  32'hDEAD,     3'b111, 1, 3'b001, 3,  1);
        tv[3]  = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 0, 3'b000, 0,  0);
        tv[4]  = mk(1, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b000, 0, 3'b000, 0,  0);
        tv[5]  = mk(0, 3'b111, 1, 2, 3,  1,  2,  3,  32'h1234_0005, 3'b111, 1, 3'b001, 1,  1);
        tv[6]  = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 1, 3'b010, 2,  1);
        tv[7]  = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 1, 3'b100, 3,  1);
        tv[8]  = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 0, 3'b000, 0,  0);
        tv[9]  = mk(0, 3'b011, 6, 4, 0,  8,  9,  0,  32'h5A5A_0009, 3'b111, 1, 3'b001, 6,  1);
        tv[10] = mk(0, 3'b011, 7, 5, 0,  10, 11, 0,  32'h5A5A_000A, 3'b111, 1, 3'b010, 4,  1);
        tv[11] = mk(0, 3'b011, 8, 10, 0, 12, 13, 0,  32'h5A5A_000B, 3'b101, 1, 3'b001, 7,  1);
        tv[12] = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b110, 1, 3'b010, 5,  1);
        tv[13] = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 1, 3'b001, 8,  1);
        tv[14] = mk(0, 3'b100, 0, 0, 9,  0,  0,  0,  32'hFFFF_FFFF, 3'b111, 1, 3'b100, 9,  0);
        tv[15] = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 0, 3'b000, 0,  0);
        tv[16] = mk(0, 3'b101, 13, 0, 11, 14, 0, 3,  32'h0C0C_0010, 3'b111, 1, 3'b001, 13, 1);
        tv[17] = mk(0, 3'b100, 0, 0, 12, 0,  0,  4,  32'h0C0C_0011, 3'b111, 1, 3'b100, 11, 1);
        tv[18] = mk(1, 3'b100, 0, 0, 14, 0,  0,  5,  32'h0C0C_0012, 3'b000, 0, 3'b000, 0,  0);
        tv[19] = mk(0, 3'b000, 0, 0, 0,  0,  0,  0,  32'h0,        3'b111, 0, 3'b000, 0,  0);

        @(negedge clk);
        for (int k = 0; k < NTV; k++) begin
            e[0] = '{slot: tv[k].s0, preg: tv[k].p0, data: tv[k].d};
            e[1] = '{slot: tv[k].s1, preg: tv[k].p1, data: tv[k].d ^ 32'h0001_0000};
            e[2] = '{slot: tv[k].s2, preg: tv[k].p2, data: tv[k].d ^ 32'h0002_0000};
            step(tv[k].rst, tv[k].val, e);
            chk($sformatf("tv%0d_rdy", k), obs_rdy, tv[k].exp_rdy);
            chk($sformatf("tv%0d_val", k), o_wb_val, tv[k].exp_val);
            chk($sformatf("tv%0d_src", k), o_wb_src, tv[k].exp_src);
            chk($sformatf("tv%0d_slot", k), o_rob_fill_slot, tv[k].exp_slot);
            chk($sformatf("tv%0d_wen", k), o_wb_rf_wen, tv[k].exp_wen);
        end

        // Random traffic; a refused source holds its payload until accepted.
        pend = '0;
        pe   = '0;
        scnt = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    logic [SLOT_W-1:0] s;
                    bit ok;
                    ok = 1'b0;
                    s  = '0;
                    for (int t = 0; t < 16 && !ok; t++) begin
                        s  = SLOT_W'(scnt + t);
                        ok = !slot_used(s);
                        for (int j = 0; j < NS; j++) if (pend[j] && pe[j].slot == s) ok = 1'b0;
                    end
                    scnt       = scnt + 1;
                    pe[i].slot = s;
                    pe[i].preg = PREG_W'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
                    pe[i].data = $urandom;
                    pend[i]    = 1'b1;
                end
            end
            step(rst, pend, pe);
            if (!rst) pend = pend & ~obs_rdy;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
